// File: rtl/ntt_bfu_pipe_if.sv
// rtl/ntt_bfu_pipe_if.sv - sample-in / result-out handshake bundle for the NTT butterfly unit
interface ntt_bfu_pipe_if #(
    parameter int unsigned W     = 12,
    parameter int unsigned TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x_in;
    logic [W-1:0]     y_in;
    logic [W-1:0]     w_in;
    logic             mode;
    logic             half;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     x_out;
    logic [W-1:0]     y_out;
    logic [TAG_W-1:0] tag_out;
    logic             range_err;
    logic             busy;

    // Stage controller / memory side: drives samples, consumes results
    modport master (
        output in_valid, x_in, y_in, w_in, mode, half, tag_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, tag_out, range_err, busy
    );

    // Butterfly unit side
    modport slave (
        input  in_valid, x_in, y_in, w_in, mode, half, tag_in, out_ready,
        output in_ready, out_valid, x_out, y_out, tag_out, range_err, busy
    );
endinterface

// File: rtl/ntt_bfu_pipe.sv
// rtl/ntt_bfu_pipe.sv - 4-stage radix-2 CT/GS NTT butterfly with Barrett reduction and backpressure
module ntt_bfu_pipe #(
    parameter int unsigned W     = 12,
    parameter int unsigned Q     = 3329,
    parameter int unsigned TAG_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    ntt_bfu_pipe_if.slave bus
);
    localparam longint unsigned MU_L = (64'd1 << (2 * W)) / Q;
    localparam logic [W:0]      MU   = MU_L[W:0];
    localparam logic [W-1:0]    QW   = W'(Q);

    // Modular halving: v/2 for even v, (v+Q)/2 for odd v
    function automatic logic [W-1:0] halve(input logic [W-1:0] v);
        logic [W:0] s;
        s = v[0] ? ({1'b0, v} + {1'b0, QW}) : {1'b0, v};
        return W'(s >> 1);
    endfunction

    logic stall;

    logic             s1_v, s1_mode, s1_half, s1_err;
    logic [W-1:0]     s1_x, s1_y;
    logic [2*W-1:0]   s1_z;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_v, s2_mode, s2_half, s2_err;
    logic [W-1:0]     s2_x, s2_y;
    logic [W+1:0]     s2_z;
    logic [W:0]       s2_t;
    logic [TAG_W-1:0] s2_tag;

    logic             s3_v, s3_mode, s3_half, s3_err;
    logic [W-1:0]     s3_x, s3_y, s3_r;
    logic [TAG_W-1:0] s3_tag;

    // Every stage freezes together when the output register is full and not drained
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign bus.busy     = s1_v || s2_v || s3_v || bus.out_valid;

    // Stage 1 operand selection: GS multiplies the modular difference, CT multiplies y
    logic [W-1:0]   gs_a_c, mul_op_c;
    logic [2*W-1:0] z_c;
    logic           err_c;
    assign gs_a_c   = (bus.x_in < bus.y_in) ? (bus.x_in - bus.y_in + QW) : (bus.x_in - bus.y_in);
    assign mul_op_c = bus.mode ? gs_a_c : bus.y_in;
    assign z_c      = {{W{1'b0}}, bus.w_in} * {{W{1'b0}}, mul_op_c};
    assign err_c    = (bus.x_in >= QW) || (bus.y_in >= QW) || (bus.w_in >= QW);

    // Stage 1 register: operands, product and per-sample control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v    <= 1'b0;
            s1_mode <= 1'b0;
            s1_half <= 1'b0;
            s1_err  <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_z    <= '0;
            s1_tag  <= '0;
        end else if (!stall) begin
            s1_v    <= bus.in_valid;
            s1_mode <= bus.mode;
            s1_half <= bus.half;
            s1_err  <= err_c;
            s1_x    <= bus.x_in;
            s1_y    <= bus.y_in;
            s1_z    <= z_c;
            s1_tag  <= bus.tag_in;
        end
    end

    // Stage 2 Barrett quotient estimate t = (z*MU) >> 2W
    logic [3*W:0] bq_prod_c;
    logic [W:0]   t_c;
    assign bq_prod_c = {{(W+1){1'b0}}, s1_z} * {{(2*W){1'b0}}, MU};
    assign t_c       = (W+1)'(bq_prod_c >> (2 * W));

    // Stage 2 register: only the low W+2 bits of z are needed for the remainder
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_v    <= 1'b0;
            s2_mode <= 1'b0;
            s2_half <= 1'b0;
            s2_err  <= 1'b0;
            s2_x    <= '0;
            s2_y    <= '0;
            s2_z    <= '0;
            s2_t    <= '0;
            s2_tag  <= '0;
        end else if (!stall) begin
            s2_v    <= s1_v;
            s2_mode <= s1_mode;
            s2_half <= s1_half;
            s2_err  <= s1_err;
            s2_x    <= s1_x;
            s2_y    <= s1_y;
            s2_z    <= (W+2)'(s1_z);
            s2_t    <= t_c;
            s2_tag  <= s1_tag;
        end
    end

    // Stage 3 remainder: true r < 3Q fits in W+2 bits, so two corrections suffice
    logic [W+1:0] tq_c, r0_c, r1_c, r2_c, qx_c;
    assign qx_c = {2'b00, QW};
    assign tq_c = (W+2)'({{(W+2){1'b0}}, s2_t} * {{(W+3){1'b0}}, QW});
    assign r0_c = s2_z - tq_c;
    assign r1_c = (r0_c >= qx_c) ? (r0_c - qx_c) : r0_c;
    assign r2_c = (r1_c >= qx_c) ? (r1_c - qx_c) : r1_c;

    // Stage 3 register: reduced product and delayed operands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_v    <= 1'b0;
            s3_mode <= 1'b0;
            s3_half <= 1'b0;
            s3_err  <= 1'b0;
            s3_x    <= '0;
            s3_y    <= '0;
            s3_r    <= '0;
            s3_tag  <= '0;
        end else if (!stall) begin
            s3_v    <= s2_v;
            s3_mode <= s2_mode;
            s3_half <= s2_half;
            s3_err  <= s2_err;
            s3_x    <= s2_x;
            s3_y    <= s2_y;
            s3_r    <= W'(r2_c);
            s3_tag  <= s2_tag;
        end
    end

    // Stage 4 butterfly: one conditional correction per modular add/subtract
    logic [W:0]   ct_s_c, gs_s_c, qe_c;
    logic [W-1:0] ct_x_c, ct_y_c, gs_x_c, res_x_c, res_y_c;
    assign qe_c    = {1'b0, QW};
    assign ct_s_c  = {1'b0, s3_x} + {1'b0, s3_r};
    assign ct_x_c  = W'((ct_s_c >= qe_c) ? (ct_s_c - qe_c) : ct_s_c);
    assign ct_y_c  = (s3_x >= s3_r) ? (s3_x - s3_r) : (s3_x + QW - s3_r);
    assign gs_s_c  = {1'b0, s3_x} + {1'b0, s3_y};
    assign gs_x_c  = W'((gs_s_c >= qe_c) ? (gs_s_c - qe_c) : gs_s_c);
    assign res_x_c = s3_mode ? gs_x_c : ct_x_c;
    assign res_y_c = s3_mode ? s3_r   : ct_y_c;

    // Output register: results, optional halving, tag and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.x_out     <= '0;
            bus.y_out     <= '0;
            bus.tag_out   <= '0;
            bus.range_err <= 1'b0;
        end else if (!stall) begin
            bus.out_valid <= s3_v;
            bus.x_out     <= s3_half ? halve(res_x_c) : res_x_c;
            bus.y_out     <= s3_half ? halve(res_y_c) : res_y_c;
            bus.tag_out   <= s3_tag;
            bus.range_err <= s3_err;
        end
    end
endmodule

// File: tb/tb_ntt_bfu_pipe.sv
// tb/tb_ntt_bfu_pipe.sv - scoreboard bench for the NTT butterfly pipeline
module tb_ntt_bfu_pipe;
    localparam int W     = 12;
    localparam int Q     = 3329;
    localparam int TAG_W = 8;

    typedef struct {
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               due;
        bit               chk_lat;
    } ent_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;
    bit   lat_chk;
    bit   rnd_en;
    ent_t sb[$];

    ntt_bfu_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

    ntt_bfu_pipe #(.W(W), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic ent_t model(input int x, input int y, input int w,
                                   input bit md, input bit hf, input int tg);
        ent_t e;
        int r, xo, yo, inv2;
        inv2 = (Q + 1) / 2;
        if (!md) begin
            r  = (w * y) % Q;
            xo = (x + r) % Q;
            yo = (x - r + Q) % Q;
        end else begin
            xo = (x + y) % Q;
            yo = (w * ((x - y + Q) % Q)) % Q;
        end
        if (hf) begin
            xo = (xo * inv2) % Q;
            yo = (yo * inv2) % Q;
        end
        e.x       = W'(xo);
        e.y       = W'(yo);
        e.tag     = TAG_W'(tg);
        e.err     = (x >= Q) || (y >= Q) || (w >= Q);
        e.due     = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Random downstream backpressure, applied away from the main driver's update time
    always @(posedge clk) begin
        #2;
        if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: handshake invariant, scoreboard push on input transfer, pop/compare on output transfer
    always @(negedge clk) begin
        if (reset) begin
            ent_t e;
            chk("in_ready_rule", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 32'(bus.tag_out), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("tag_out", 32'(bus.tag_out), 32'(e.tag));
                    chk("range_err", 32'(bus.range_err), 32'(e.err));
                    if (!e.err) begin
                        chk("x_out", 32'(bus.x_out), 32'(e.x));
                        chk("y_out", 32'(bus.y_out), 32'(e.y));
                    end
                    if (e.chk_lat) chk("latency", 32'(cyc), 32'(e.due));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(int'(bus.x_in), int'(bus.y_in), int'(bus.w_in),
                          bus.mode, bus.half, int'(bus.tag_in));
                e.due     = cyc + 4;
                e.chk_lat = lat_chk;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input int x, input int y, input int w, input bit md, input bit hf, input int tg);
        int k;
        bus.in_valid = 1'b1;
        bus.x_in     = W'(x);
        bus.y_in     = W'(y);
        bus.w_in     = W'(w);
        bus.mode     = md;
        bus.half     = hf;
        bus.tag_in   = TAG_W'(tg);
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("send_timeout", 32'(k), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        n_tests       = 0;
        n_fail        = 0;
        cyc           = 0;
        lat_chk       = 1'b0;
        rnd_en        = 1'b0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.w_in      = '0;
        bus.mode      = 1'b0;
        bus.half      = 1'b0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_x_out", 32'(bus.x_out), 32'd0);
        chk("rst_y_out", 32'(bus.y_out), 32'd0);
        chk("rst_tag_out", 32'(bus.tag_out), 32'd0);
        chk("rst_range_err", 32'(bus.range_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed vectors with latency checking
        lat_chk = 1'b1;
        send(5, 7, 17, 1'b0, 1'b0, 8'h11);
        drain();
        send(5, 7, 17, 1'b1, 1'b0, 8'h22);
        send(5, 7, 17, 1'b1, 1'b1, 8'h33);
        send(3328, 3328, 3328, 1'b0, 1'b0, 8'h44);
        send(0, 0, 0, 1'b0, 1'b0, 8'h55);
        drain();

        // Out-of-range operand followed by a clean sample
        send(3329, 7, 17, 1'b0, 1'b0, 8'h66);
        send(5, 7, 17, 1'b0, 1'b0, 8'h67);
        drain();

        // Held output while downstream is not ready
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        send(100, 200, 300, 1'b0, 1'b1, 8'h70);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("stall_reach", 32'(bus.out_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (sb.size() != 0) begin
                chk("stall_x_out", 32'(bus.x_out), 32'(sb[0].x));
                chk("stall_y_out", 32'(bus.y_out), 32'(sb[0].y));
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Random back-to-back stream under random backpressure
        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
                 int'($urandom_range(0, Q - 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'h80 + i);
        end
        rnd_en        = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Asynchronous reset with samples in flight
        send(1, 2, 3, 1'b0, 1'b0, 8'hA0);
        send(4, 5, 6, 1'b1, 1'b0, 8'hA1);
        send(7, 8, 9, 1'b0, 1'b1, 8'hA2);
        chk("busy_in_flight", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        lat_chk = 1'b1;
        send(5, 7, 17, 1'b0, 1'b0, 8'hB0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_bfu_pipe.md
Name: ntt_bfu_pipe

Overview:
- Parametrised radix-2 NTT butterfly unit and the successor of the fixed-width, enable-only butterfly pipeline.
- Supports two butterfly modes per sample:
  - Cooley-Tukey (CT), for the forward transform.
  - Gentleman-Sande (GS), for the inverse transform.
- Optional divide-by-2 scaling for the inverse transform.
- Barrett modular reduction, full valid/ready backpressure and a sideband tag.
- Sits between the coefficient memory read/write ports and the NTT stage controller.

Parameters:
- W, 12: coefficient width in bits. Requires Q < 2^W.
- Q, 3329: prime modulus. Q must be odd and satisfy 2^(W-1) < Q < 2^W.
- TAG_W, 8: width of the sideband tag carried alongside each sample.
- MU, floor(2^(2W)/Q) = 5039 at the defaults: Barrett constant. Localparam, derived from W and Q, not overridable.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: unit can accept a sample this cycle.
- x_in, input, W: butterfly operand x.
- y_in, input, W: butterfly operand y.
- w_in, input, W: twiddle factor.
- mode, input, 1: 0 = CT, 1 = GS.
- half, input, 1: 1 = multiply both outputs by 2^-1 mod Q.
- tag_in, input, TAG_W: sideband tag, passed through unchanged.
- out_valid, output, 1: output sample valid.
- out_ready, input, 1: downstream accepts the output sample.
- x_out, output, W: result x'.
- y_out, output, W: result y'.
- tag_out, output, TAG_W: tag belonging to the current output sample.
- range_err, output, 1: at least one of x_in, y_in, w_in was >= Q for this sample.
- busy, output, 1: at least one pipeline stage holds a valid sample.

Behaviour:
- Reset: all stage valid bits, out_valid, x_out, y_out, tag_out, range_err and busy go to 0. Reset is asynchronous, so samples in flight are discarded immediately. in_ready is 1 during and after reset.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stall is high, every stage register holds its value, including bubbles.
- Pipeline: 4 stages, latency 4 cycles with no stall. Throughput is 1 sample per cycle.
- Stage 1 (operand and product):
  - Operands and flags are registered.
  - CT: multiplier operand m = y; product z = w*y.
  - GS: a = (x - y) mod Q, computed as x - y, plus Q when x < y. The difference a is the multiplier operand, so z = w*a.
  - In both modes z is 2W bits wide.
  - range_err is computed here and carried along the pipe.
- Stage 2 (Barrett quotient): t = (z * MU) >> (2W).
- Stage 3 (Barrett remainder):
  - r = z - t*Q, computed on W+2 bits.
  - Subtract Q while r >= Q, at most two conditional subtractions.
  - Result: r in [0, Q).
- Stage 4 (output butterfly):
  - CT: x' = (x + r) mod Q; y' = (x - r) mod Q.
  - GS: x' = (x + y) mod Q; y' = r.
  - Each mod step is a single conditional add or subtract of Q.
  - The x and y values used here are delayed copies taken from stage 1.
- Halving: when half = 1, each result v becomes v >> 1 if v is even, and (v + Q) >> 1 if v is odd. Halving is applied inside stage 4 and does not add latency.
- Per-sample control: mode, half and tag are captured with each sample, so consecutive samples may use different modes with no bubble.
- Out-of-range inputs: x_out and y_out are don't-care for a flagged sample. range_err is asserted together with that sample's out_valid. The pipeline does not stop on an error.
- Simultaneous input transfer and output drain while out_ready = 1: normal advance, no bubble inserted.
- Output stability: out_valid and all output data stay stable while stalled.
- busy = OR of all stage valid bits.

Test Plan:
- Q=3329, CT, half=0: x=5, y=7, w=17 -> x_out=124, y_out=3215, out_valid exactly 4 cycles after the input transfer, tag_out equals tag_in.
- GS boundary sample: x=5, y=7, w=17 -> x_out=12, y_out=3295. Same inputs with half=1 -> x_out=6, y_out=3312.
- CT wrap case: x=3328, y=3328, w=3328 -> x_out=0, y_out=3327. Also x=0, y=0, w=0 -> 0, 0.
- Backpressure: stream 20 random CT/GS samples back to back with out_ready toggling randomly. Required: no loss or duplication, in-order tags, results match the model, in_ready = !(out_valid && !out_ready) every cycle.
- x_in=3329 -> range_err=1 on that sample only; the following valid sample has range_err=0 and a correct result.
- Reset asserted with 3 samples in flight -> out_valid=0 and busy=0 immediately. After release, a new sample appears exactly 4 cycles after its input transfer.
